sramlike_arbiter: RTL and testbench



---
 rtl/sramlike_arb_pkg.sv | 17 +
 rtl/sramlike_arb_owner_fifo.sv | 56 +++++
 rtl/sramlike_arbiter.sv | 133 +++++++++++++
 tb/tb_sramlike_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sramlike_arb_pkg.sv
// Shared types and defaults for the two-to-one sram-like arbiter.
package sramlike_arb_pkg;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_OUTSTANDING_DEPTH = 2;
    localparam int unsigned DEFAULT_STARVE_LIMIT      = 4;

endpackage

// File: rtl/sramlike_arb_owner_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding transaction.
// Push while full and pop while empty are ignored.
module sramlike_arb_owner_fifo
    import sramlike_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_OUTSTANDING_DEPTH
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic                         push,
    input  logic                         pop,
    input  owner_e                       din,
    output owner_e                       dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e           tags [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = tags[rd_ptr];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Tag storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge hclk) begin
        if (do_push) tags[wr_ptr] <= din;
    end

endmodule

// File: rtl/sramlike_arbiter.sv
// Shares one downstream sram-like port between fetch (if_*) and memory (mem_*) requesters.
// Define SRAMLIKE_ARB_STARVE_EN to add the fetch starvation guard; otherwise mem has strict priority.
module sramlike_arbiter
    import sramlike_arb_pkg::*;
#(
    parameter int unsigned OUTSTANDING_DEPTH = DEFAULT_OUTSTANDING_DEPTH,
    parameter int unsigned STARVE_LIMIT      = DEFAULT_STARVE_LIMIT
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [3:0]  if_ben,
    input  logic        if_wr,
    input  logic [31:0] if_addr,
    input  logic [31:0] if_wdata,
    output logic        if_addr_ok,
    output logic        if_data_ok,
    output logic [31:0] if_rdata,
    input  logic [3:0]  mem_ben,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_addr_ok,
    output logic        mem_data_ok,
    output logic [31:0] mem_rdata,
    output logic [3:0]  m_ben,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING_DEPTH + 1);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           sel;
    owner_e           head_owner;
    logic             if_req, mem_req;
    logic             starve_force;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_fifo_count;

    assign if_req            = |if_ben;
    assign mem_req           = |mem_ben;
    assign fifo_push         = |m_ben & m_addr_ok;
    assign if_rdata          = m_rdata;
    assign mem_rdata         = m_rdata;
    assign unused_fifo_count = ^fifo_count;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ARB;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // A presented but unaccepted address phase locks its owner until accepted.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB: begin
                if (|m_ben && !m_addr_ok) begin
                    state_d = LOCK;
                    owner_d = sel;
                end
            end
            LOCK: begin
                if (m_addr_ok) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        sel = OWN_MEM;
        if (state_q == LOCK)                          sel = owner_q;
        else if (if_req && (!mem_req || starve_force)) sel = OWN_IF;

        m_wr    = (sel == OWN_MEM) ? mem_wr    : if_wr;
        m_addr  = (sel == OWN_MEM) ? mem_addr  : if_addr;
        m_wdata = (sel == OWN_MEM) ? mem_wdata : if_wdata;
        m_ben   = fifo_full ? 4'b0 : ((sel == OWN_MEM) ? mem_ben : if_ben);

        if_addr_ok  = m_addr_ok & ~fifo_full & if_req  & (sel == OWN_IF);
        mem_addr_ok = m_addr_ok & ~fifo_full & mem_req & (sel == OWN_MEM);

        if_data_ok  = m_data_ok & ~fifo_empty & (head_owner == OWN_IF);
        mem_data_ok = m_data_ok & ~fifo_empty & (head_owner == OWN_MEM);
    end

`ifdef SRAMLIKE_ARB_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // Counts mem accepts that happened while fetch was waiting; saturates at the limit.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            starve_cnt <= '0;
        end else if (!if_req || (fifo_push && sel == OWN_IF)) begin
            starve_cnt <= '0;
        end else if (fifo_push && sel == OWN_MEM && !starve_force) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    sramlike_arb_owner_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_fifo (
        .hclk   (hclk),
        .hreset (hreset),
        .push   (fifo_push),
        .pop    (m_data_ok),
        .din    (sel),
        .dout   (head_owner),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Table-driven bench for sramlike_arbiter; one record per clock cycle, inputs driven
// after the falling edge and outputs compared before the next rising edge.
module tb_sramlike_arbiter;
    import sramlike_arb_pkg::*;

`ifdef SRAMLIKE_ARB_STARVE_EN
    localparam logic STARVE = 1'b1;
`else
    localparam logic STARVE = 1'b0;
`endif

    localparam logic [3:0]  BF = 4'hF;
    localparam logic [3:0]  BM = 4'h3;
    localparam logic [3:0]  B0 = 4'h0;
    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] IB = 32'hBFC0_0004;
    localparam logic [31:0] MA = 32'h0000_1000;
    localparam logic [31:0] Z  = 32'h0;

    typedef struct {
        logic        rst;
        logic [3:0]  if_ben;
        logic [31:0] if_addr;
        logic [3:0]  mem_ben;
        logic [31:0] mem_addr;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic [3:0]  e_ben;
        logic        e_wr;
        logic [31:0] e_addr;
        logic        chk_addr;
        logic        e_if_aok;
        logic        e_mem_aok;
        logic        e_if_dok;
        logic        e_mem_dok;
        int          e_count;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [3:0]  if_ben, mem_ben, m_ben;
    logic        if_wr, mem_wr, m_wr;
    logic [31:0] if_addr, if_wdata, mem_addr, mem_wdata, m_addr, m_wdata;
    logic        if_addr_ok, if_data_ok, mem_addr_ok, mem_data_ok;
    logic [31:0] if_rdata, mem_rdata, m_rdata;
    logic        m_addr_ok, m_data_ok;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl [19];
    vec_t starve_seq [8];
    vec_t reset_seq [5];

    sramlike_arbiter dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .if_ben      (if_ben),
        .if_wr       (if_wr),
        .if_addr     (if_addr),
        .if_wdata    (if_wdata),
        .if_addr_ok  (if_addr_ok),
        .if_data_ok  (if_data_ok),
        .if_rdata    (if_rdata),
        .mem_ben     (mem_ben),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .m_ben       (m_ben),
        .m_wr        (m_wr),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_addr_ok   (m_addr_ok),
        .m_data_ok   (m_data_ok),
        .m_rdata     (m_rdata)
    );

    always #5 hclk = ~hclk;

    function automatic vec_t row(
        input logic rst, input logic [3:0] ib, input logic [31:0] ia,
        input logic [3:0] mb, input logic [31:0] ma,
        input logic aok, input logic dok, input logic [31:0] rd,
        input logic [3:0] eb, input logic ew, input logic [31:0] ea, input logic ca,
        input logic eia, input logic ema, input logic eid, input logic emd, input int ec);
        vec_t v;
        v.rst = rst;     v.if_ben = ib;    v.if_addr = ia;
        v.mem_ben = mb;  v.mem_addr = ma;
        v.aok = aok;     v.dok = dok;      v.rdata = rd;
        v.e_ben = eb;    v.e_wr = ew;      v.e_addr = ea;    v.chk_addr = ca;
        v.e_if_aok = eia; v.e_mem_aok = ema; v.e_if_dok = eid; v.e_mem_dok = emd;
        v.e_count = ec;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        hreset    = v.rst;
        if_ben    = v.if_ben;
        if_addr   = v.if_addr;
        mem_ben   = v.mem_ben;
        mem_addr  = v.mem_addr;
        m_addr_ok = v.aok;
        m_data_ok = v.dok;
        m_rdata   = v.rdata;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_row(input string tag, input vec_t v);
        @(negedge hclk);
        apply_stimulus(v);
        #1;
        check_output({tag, ".m_ben"}, 32'(m_ben), 32'(v.e_ben));
        if (v.chk_addr) begin
            check_output({tag, ".m_addr"}, m_addr, v.e_addr);
            check_output({tag, ".m_wr"}, 32'(m_wr), 32'(v.e_wr));
        end
        check_output({tag, ".if_addr_ok"},  32'(if_addr_ok),  32'(v.e_if_aok));
        check_output({tag, ".mem_addr_ok"}, 32'(mem_addr_ok), 32'(v.e_mem_aok));
        check_output({tag, ".if_data_ok"},  32'(if_data_ok),  32'(v.e_if_dok));
        check_output({tag, ".mem_data_ok"}, 32'(mem_data_ok), 32'(v.e_mem_dok));
        check_output({tag, ".if_rdata"},  if_rdata,  v.rdata);
        check_output({tag, ".mem_rdata"}, mem_rdata, v.rdata);
        check_output({tag, ".fifo_count"}, 32'(dut.fifo_count), 32'(v.e_count));
    endtask

    initial begin
        hreset = 1'b1;
        if_ben = B0;  if_wr = 1'b0;  if_addr = Z;  if_wdata = 32'hAAAA_0000;
        mem_ben = B0; mem_wr = 1'b1; mem_addr = Z; mem_wdata = 32'h5555_0000;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = Z;

        //                 rst if_ben/addr  mem_ben/addr aok dok rdata           e_ben e_wr e_addr chk  iaok maok idok mdok cnt
        // single fetch read, data two cycles after accept
        tbl[0]  = row(0, BF, IA, B0, Z,  1, 0, Z,             BF, 0, IA, 1,  1, 0, 0, 0, 0);
        tbl[1]  = row(0, B0, Z,  B0, Z,  0, 0, Z,             B0, 0, Z,  0,  0, 0, 0, 0, 1);
        tbl[2]  = row(0, B0, Z,  B0, Z,  0, 1, 32'h12345678,  B0, 0, Z,  0,  0, 0, 1, 0, 1);
        // simultaneous requests: mem first, then fetch; returns in order
        tbl[3]  = row(0, BF, IA, BM, MA, 1, 0, Z,             BM, 1, MA, 1,  0, 1, 0, 0, 0);
        tbl[4]  = row(0, BF, IA, B0, Z,  1, 0, Z,             BF, 0, IA, 1,  1, 0, 0, 0, 1);
        tbl[5]  = row(0, B0, Z,  B0, Z,  0, 1, 32'hA1A1A1A1,  B0, 0, Z,  0,  0, 0, 0, 1, 2);
        tbl[6]  = row(0, B0, Z,  B0, Z,  0, 1, 32'hB2B2B2B2,  B0, 0, Z,  0,  0, 0, 1, 0, 1);
        // fetch stalled three cycles, then mem arrives; lock keeps fetch
        tbl[7]  = row(0, BF, IA, B0, Z,  0, 0, Z,             BF, 0, IA, 1,  0, 0, 0, 0, 0);
        tbl[8]  = row(0, BF, IA, B0, Z,  0, 0, Z,             BF, 0, IA, 1,  0, 0, 0, 0, 0);
        tbl[9]  = row(0, BF, IA, B0, Z,  0, 0, Z,             BF, 0, IA, 1,  0, 0, 0, 0, 0);
        tbl[10] = row(0, BF, IA, BM, MA, 0, 0, Z,             BF, 0, IA, 1,  0, 0, 0, 0, 0);
        tbl[11] = row(0, BF, IA, BM, MA, 1, 0, Z,             BF, 0, IA, 1,  1, 0, 0, 0, 0);
        tbl[12] = row(0, B0, Z,  BM, MA, 1, 0, Z,             BM, 1, MA, 1,  0, 1, 0, 0, 1);
        // FIFO full: blocked even with a pop, accept resumes the next cycle
        tbl[13] = row(0, BF, IB, B0, Z,  1, 0, Z,             B0, 0, IB, 1,  0, 0, 0, 0, 2);
        tbl[14] = row(0, BF, IB, B0, Z,  1, 1, 32'hC3C3C3C3,  B0, 0, IB, 1,  0, 0, 1, 0, 2);
        tbl[15] = row(0, BF, IB, B0, Z,  1, 0, Z,             BF, 0, IB, 1,  1, 0, 0, 0, 1);
        tbl[16] = row(0, B0, Z,  B0, Z,  0, 1, 32'hD4D4D4D4,  B0, 0, Z,  0,  0, 0, 0, 1, 2);
        tbl[17] = row(0, B0, Z,  B0, Z,  0, 1, 32'hE5E5E5E5,  B0, 0, Z,  0,  0, 0, 1, 0, 1);
        // return with nothing outstanding is dropped
        tbl[18] = row(0, B0, Z,  B0, Z,  0, 1, 32'hF6F6F6F6,  B0, 0, Z,  0,  0, 0, 0, 0, 0);

        // mem streams while fetch waits; fetch wins the fifth decision only with the guard
        starve_seq[0] = row(0, BF, IA, BM, MA,     1, 0, Z,            BM, 1, MA, 1, 0, 1, 0, 0, 0);
        starve_seq[1] = row(0, BF, IA, BM, MA + 4, 1, 1, 32'h00000011, BM, 1, MA + 4, 1, 0, 1, 0, 1, 1);
        starve_seq[2] = row(0, BF, IA, BM, MA + 8, 1, 1, 32'h00000022, BM, 1, MA + 8, 1, 0, 1, 0, 1, 1);
        starve_seq[3] = row(0, BF, IA, BM, MA + 12, 1, 1, 32'h00000033, BM, 1, MA + 12, 1, 0, 1, 0, 1, 1);
        starve_seq[4] = row(0, BF, IA, BM, MA + 16, 1, 1, 32'h00000044,
                            STARVE ? BF : BM, ~STARVE, STARVE ? IA : MA + 16, 1,
                            STARVE, ~STARVE, 0, 1, 1);
        starve_seq[5] = row(0, B0, Z,  BM, MA + 16, 1, 1, 32'h00000055, BM, 1, MA + 16, 1,
                            0, 1, STARVE, ~STARVE, 1);
        starve_seq[6] = row(0, B0, Z,  B0, Z, 0, 1, 32'h00000066, B0, 0, Z, 0, 0, 0, 0, 1, 1);
        starve_seq[7] = row(0, B0, Z,  B0, Z, 0, 0, Z,            B0, 0, Z, 0, 0, 0, 0, 0, 0);

        // reset with two outstanding, then a stale return
        reset_seq[0] = row(0, BF, IA, B0, Z,  1, 0, Z,            BF, 0, IA, 1, 1, 0, 0, 0, 0);
        reset_seq[1] = row(0, B0, Z,  BM, MA, 1, 0, Z,            BM, 1, MA, 1, 0, 1, 0, 0, 1);
        reset_seq[2] = row(1, B0, Z,  B0, Z,  0, 0, Z,            B0, 0, Z,  0, 0, 0, 0, 0, 2);
        reset_seq[3] = row(0, B0, Z,  B0, Z,  0, 1, 32'hDEADBEEF, B0, 0, Z,  0, 0, 0, 0, 0, 0);
        reset_seq[4] = row(0, B0, Z,  B0, Z,  0, 0, Z,            B0, 0, Z,  0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge hclk);
        run_row("reset", row(1, B0, Z, B0, Z, 0, 0, Z, B0, 0, Z, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 19; i++) run_row($sformatf("tbl%0d", i), tbl[i]);
        for (int i = 0; i < 8; i++)  run_row($sformatf("starve%0d", i), starve_seq[i]);
        for (int i = 0; i < 5; i++)  run_row($sformatf("rst%0d", i), reset_seq[i]);

        @(negedge hclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
